// File: rtl/ssp_pkg.sv
// Shared definitions for the SSP receive path: FSM states and width defaults.
package ssp_pkg;

  localparam int SSP_MAX_WIDTH   = 8;
  localparam int SSP_SYNC_STAGES = 2;
  localparam int SSP_CNT_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WRITE = 2'd2
  } ssp_state_e;

endpackage

// File: rtl/ssp_rx_ctrl_if.sv
// Receive-FIFO write port: parallel word, one-cycle strobe and the FIFO full flag.
interface ssp_rx_ctrl_if;

  logic [ssp_pkg::SSP_MAX_WIDTH-1:0] RX_DATA;
  logic                              RX_WRITE;
  logic                              FIFO_FULL;

  modport master (output RX_DATA, output RX_WRITE, input FIFO_FULL);
  modport slave  (input RX_DATA, input RX_WRITE, output FIFO_FULL);

endinterface

// File: rtl/ssp_sync_edge.sv
// Equal-depth synchronisers for the serial clock and its companion data lines,
// plus a one-cycle falling-edge pulse on the synchronised serial clock.
module ssp_sync_edge #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             async_clk_i,
  input  logic [WIDTH-1:0] async_data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             fe_o
);

  logic [STAGES-1:0]            clk_q;
  logic [STAGES-1:0][WIDTH-1:0] data_q;
  logic                         clk_prev_q;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_q      <= '0;
      data_q     <= '0;
      clk_prev_q <= 1'b0;
    end else begin
      clk_q[0]  <= async_clk_i;
      data_q[0] <= async_data_i;
      for (int i = 1; i < STAGES; i++) begin
        clk_q[i]  <= clk_q[i-1];
        data_q[i] <= data_q[i-1];
      end
      clk_prev_q <= clk_q[STAGES-1];
    end
  end

  assign data_o = data_q[STAGES-1];
  assign fe_o   = clk_prev_q & ~clk_q[STAGES-1];

endmodule

// File: rtl/ssp_rx_ctrl.sv
// SSP receive sequencer: deserialises TI-SSI frames and strobes each word into
// the receive FIFO, flagging a sticky overrun when the FIFO is full.
module ssp_rx_ctrl
  import ssp_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = SSP_SYNC_STAGES
) (
  input  logic                 PCLK,
  input  logic                 CLEAR_B,
  input  logic                 ENABLE,
  input  logic                 SSPCLKIN,
  input  logic                 SSPFSSIN,
  input  logic                 SSPRXD,
  input  logic                 OVR_CLR,
  ssp_rx_ctrl_if.master        fifo,
  output logic                 OVERRUN,
  output logic                 BUSY
);

  localparam logic [SSP_CNT_W-1:0] LAST_BIT = SSP_CNT_W'(DATA_WIDTH - 1);

  ssp_state_e               state_q, state_d;
  logic [SSP_CNT_W-1:0]     cnt_q, cnt_d;
  logic [SSP_MAX_WIDTH-1:0] shift_q, shift_d;
  logic                     b2b_q, b2b_d;
  logic [SSP_MAX_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                     rx_write_q, rx_write_d;
  logic                     ovr_q, ovr_d;

  logic fe, fss_s, rxd_s;

  ssp_sync_edge #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (2)
  ) u_sync (
    .clk          (PCLK),
    .rst_n        (CLEAR_B),
    .async_clk_i  (SSPCLKIN),
    .async_data_i ({SSPRXD, SSPFSSIN}),
    .data_o       ({rxd_s, fss_s}),
    .fe_o         (fe)
  );

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every variable assigned here gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    b2b_d   = b2b_q;
    if (!ENABLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      shift_d = '0;
      b2b_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (fe && fss_s) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
            shift_d = '0;
          end
        end
        ST_SHIFT: begin
          if (fe) begin
            shift_d = {shift_q[SSP_MAX_WIDTH-2:0], rxd_s};
            cnt_d   = cnt_q + SSP_CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
              state_d = ST_WRITE;
              cnt_d   = '0;
              b2b_d   = fss_s;
            end
          end
        end
        ST_WRITE: begin
          // A frame sync seen on the last bit means the next MSB is already due.
          if (b2b_q) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
            b2b_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_write_d = (state_q == ST_WRITE) && ENABLE && !fifo.FIFO_FULL;
    rx_data_d  = rx_write_d ? shift_q : rx_data_q;
    ovr_d      = ovr_q;
    if ((state_q == ST_WRITE) && ENABLE && fifo.FIFO_FULL) ovr_d = 1'b1;
    else if (OVR_CLR)                                      ovr_d = 1'b0;
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      cnt_q      <= '0;
      shift_q    <= '0;
      b2b_q      <= 1'b0;
      rx_data_q  <= '0;
      rx_write_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      b2b_q      <= b2b_d;
      rx_data_q  <= rx_data_d;
      rx_write_q <= rx_write_d;
      ovr_q      <= ovr_d;
    end
  end

  assign fifo.RX_DATA  = rx_data_q;
  assign fifo.RX_WRITE = rx_write_q;
  assign OVERRUN       = ovr_q;
  assign BUSY          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ssp_rx_ctrl.sv
// Self-checking bench for ssp_rx_ctrl: directed vector table, timed corner
// sequences and randomised frames scored against a frame-level model.
module tb_ssp_rx_ctrl;

  localparam int SYNC = 2;

  logic PCLK = 1'b0;
  logic CLEAR_B = 1'b1;
  logic ENABLE = 1'b0, ENABLE4 = 1'b0;
  logic SSPCLKIN = 1'b0, SSPFSSIN = 1'b0, SSPRXD = 1'b0, OVR_CLR = 1'b0;
  logic OVERRUN, BUSY, OVERRUN4, BUSY4;

  ssp_rx_ctrl_if fi ();
  ssp_rx_ctrl_if fi4 ();

  ssp_rx_ctrl #(.DATA_WIDTH(8), .SYNC_STAGES(SYNC)) dut (
    .PCLK(PCLK), .CLEAR_B(CLEAR_B), .ENABLE(ENABLE), .SSPCLKIN(SSPCLKIN),
    .SSPFSSIN(SSPFSSIN), .SSPRXD(SSPRXD), .OVR_CLR(OVR_CLR), .fifo(fi),
    .OVERRUN(OVERRUN), .BUSY(BUSY));

  ssp_rx_ctrl #(.DATA_WIDTH(4), .SYNC_STAGES(SYNC)) dut4 (
    .PCLK(PCLK), .CLEAR_B(CLEAR_B), .ENABLE(ENABLE4), .SSPCLKIN(SSPCLKIN),
    .SSPFSSIN(SSPFSSIN), .SSPRXD(SSPRXD), .OVR_CLR(OVR_CLR), .fifo(fi4),
    .OVERRUN(OVERRUN4), .BUSY(BUSY4));

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic       prev_wr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge PCLK) begin
    if (fi.RX_WRITE === 1'b1) begin
      got_q.push_back(fi.RX_DATA);
      check("no_consec_write", {31'd0, prev_wr}, 32'd0);
    end
    prev_wr = fi.RX_WRITE;
  end

  task automatic ser_cycle(input logic d, input logic f, input int hi, input int lo);
    SSPCLKIN = 1'b1; SSPRXD = d; SSPFSSIN = f;
    repeat (hi) @(negedge PCLK);
    SSPCLKIN = 1'b0;
    repeat (lo) @(negedge PCLK);
  endtask

  // Sends an optional FSS lead cycle then the first nsend bits, MSB first.
  task automatic send_frame(input logic [7:0] w, input int width, input int nsend,
                            input bit lead, input int fss_bit, input int hi,
                            input int lo, input bit chk_busy);
    if (lead) ser_cycle(1'b0, 1'b1, hi, lo);
    for (int i = 0; i < nsend; i++) begin
      ser_cycle(w[width-1-i], (i == fss_bit), hi, lo);
      if (chk_busy && i == 0) check("b2b_busy", {31'd0, BUSY}, 32'd1);
    end
  endtask

  // Last bit with its falling edge timed: lat = negedges from pin fall to RX_WRITE.
  task automatic send_last_measured(input logic d, input bit use4, input bit clr3,
                                    output int lat, output logic [7:0] dat,
                                    output logic ovr4);
    logic wr;
    SSPCLKIN = 1'b1; SSPRXD = d; SSPFSSIN = 1'b0;
    repeat (4) @(negedge PCLK);
    SSPCLKIN = 1'b0;
    lat = -1; dat = '0; ovr4 = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge PCLK);
      OVR_CLR = (clr3 && n == 3);
      if (n == 4) ovr4 = OVERRUN;
      wr = use4 ? fi4.RX_WRITE : fi.RX_WRITE;
      if (lat < 0 && wr === 1'b1) begin
        lat = n;
        dat = use4 ? fi4.RX_DATA : fi.RX_DATA;
      end
    end
  endtask

  task automatic checkpoint(input string tag, input logic exp_ovr);
    repeat (8) @(negedge PCLK);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_data"}, {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
    got_q.delete();
    exp_q.delete();
    check({tag, "_overrun"}, {31'd0, OVERRUN}, {31'd0, exp_ovr});
    check({tag, "_idle"}, {31'd0, BUSY}, 32'd0);
  endtask

  task automatic pulse_clr();
    OVR_CLR = 1'b1;
    @(negedge PCLK);
    OVR_CLR = 1'b0;
  endtask

  typedef struct {
    logic [7:0] word;
    logic       full;
    int         fss_bit;
    logic       clr_after;
    logic       exp_write;
    logic [7:0] exp_data;
    logic       exp_ovr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bit         lead;
    int         lat;
    logic [7:0] dat;
    logic       ovr4;
    logic       model_ovr;
    logic       full;
    logic [7:0] w;
    int         hi, lo, mid, clen, k;

    tbl[0] = '{8'hA5, 1'b0, -1, 1'b0, 1'b1, 8'hA5, 1'b0};
    tbl[1] = '{8'h3C, 1'b0,  7, 1'b0, 1'b1, 8'h3C, 1'b0};
    tbl[2] = '{8'hC3, 1'b0, -1, 1'b0, 1'b1, 8'hC3, 1'b0};
    tbl[3] = '{8'h55, 1'b1, -1, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[4] = '{8'h66, 1'b0, -1, 1'b1, 1'b1, 8'h66, 1'b1};
    tbl[5] = '{8'h9A, 1'b0,  3, 1'b0, 1'b1, 8'h9A, 1'b0};

    fi.FIFO_FULL = 1'b0;
    fi4.FIFO_FULL = 1'b0;
    #2 CLEAR_B = 1'b0;
    repeat (3) @(negedge PCLK);
    check("rst_rx_data", {24'd0, fi.RX_DATA}, 32'd0);
    check("rst_rx_write", {31'd0, fi.RX_WRITE}, 32'd0);
    check("rst_overrun", {31'd0, OVERRUN}, 32'd0);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    CLEAR_B = 1'b1;
    @(negedge PCLK);

    // FSS while disabled must not start a frame.
    ser_cycle(1'b1, 1'b1, 4, 4);
    check("disabled_fss_idle", {31'd0, BUSY}, 32'd0);
    ENABLE = 1'b1;
    repeat (4) @(negedge PCLK);

    lead = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v = tbl[i];
      fi.FIFO_FULL = v.full;
      if (v.exp_write) exp_q.push_back(v.exp_data);
      send_frame(v.word, 8, 8, lead, v.fss_bit, 4, 4, !lead);
      lead = (v.fss_bit != 7);
      if (lead) begin
        checkpoint($sformatf("vec%0d", i), v.exp_ovr);
        if (v.clr_after) begin
          pulse_clr();
          check("ovr_clr", {31'd0, OVERRUN}, 32'd0);
        end
      end
    end

    // Abort after four bits; the next frame must carry no stale bits.
    fi.FIFO_FULL = 1'b0;
    send_frame(8'hFF, 8, 4, 1'b1, -1, 4, 4, 1'b0);
    ENABLE = 1'b0;
    @(negedge PCLK);
    check("abort_idle", {31'd0, BUSY}, 32'd0);
    repeat (10) @(negedge PCLK);
    check("abort_nowrite", got_q.size(), 0);
    ENABLE = 1'b1;
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 8, 8, 1'b1, -1, 4, 4, 1'b0);
    checkpoint("abort", 1'b0);

    // Overrun set on the same edge as OVR_CLR: set must win.
    fi.FIFO_FULL = 1'b1;
    send_frame(8'h5A, 8, 7, 1'b1, -1, 4, 4, 1'b0);
    send_last_measured(1'b0, 1'b0, 1'b1, lat, dat, ovr4);
    check("ovr_set_priority", {31'd0, ovr4}, 32'd1);
    checkpoint("full_drop", 1'b1);

    model_ovr = 1'b1;
    k = 0;
    while (k < 36) begin
      full = ($urandom_range(0, 3) == 0);
      fi.FIFO_FULL = full;
      lead = 1'b1;
      clen = $urandom_range(1, 3);
      for (int j = 0; j < clen; j++) begin
        w   = 8'($urandom);
        hi  = $urandom_range(2, 5);
        lo  = $urandom_range(2, 5);
        mid = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : -1;
        if (full) model_ovr = 1'b1;
        else      exp_q.push_back(w);
        send_frame(w, 8, 8, lead, (j < clen - 1) ? 7 : mid, hi, lo, !lead);
        lead = 1'b0;
        k++;
      end
      checkpoint($sformatf("rnd%0d", k), model_ovr);
      if ($urandom_range(0, 2) == 0) begin
        pulse_clr();
        model_ovr = 1'b0;
      end
    end

    // Async reset mid-frame with non-zero outputs beforehand.
    fi.FIFO_FULL = 1'b0;
    exp_q.push_back(8'hDB);
    send_frame(8'hDB, 8, 8, 1'b1, -1, 4, 4, 1'b0);
    checkpoint("pre_rst_word", model_ovr);
    fi.FIFO_FULL = 1'b1;
    send_frame(8'h24, 8, 8, 1'b1, -1, 4, 4, 1'b0);
    checkpoint("pre_rst_ovr", 1'b1);
    fi.FIFO_FULL = 1'b0;
    send_frame(8'h81, 8, 5, 1'b1, -1, 4, 4, 1'b0);
    @(posedge PCLK);
    #2 CLEAR_B = 1'b0;
    #1;
    check("arst_rx_data", {24'd0, fi.RX_DATA}, 32'd0);
    check("arst_rx_write", {31'd0, fi.RX_WRITE}, 32'd0);
    check("arst_overrun", {31'd0, OVERRUN}, 32'd0);
    check("arst_busy", {31'd0, BUSY}, 32'd0);
    @(negedge PCLK);
    CLEAR_B = 1'b1;
    repeat (4) @(negedge PCLK);
    got_q.delete();
    send_frame(8'h81, 8, 7, 1'b1, -1, 4, 4, 1'b0);
    send_last_measured(1'b1, 1'b0, 1'b0, lat, dat, ovr4);
    check("latency8", lat, SYNC + 2);
    check("post_rst_data", {24'd0, dat}, 32'h81);
    exp_q.push_back(8'h81);
    checkpoint("post_rst", 1'b0);

    // Narrow instance: 4-bit frame, right-justified word.
    ENABLE = 1'b0;
    ENABLE4 = 1'b1;
    repeat (4) @(negedge PCLK);
    send_frame(8'h0B, 4, 3, 1'b1, -1, 4, 4, 1'b0);
    send_last_measured(1'b1, 1'b1, 1'b0, lat, dat, ovr4);
    check("dw4_latency", lat, SYNC + 2);
    check("dw4_data", {24'd0, dat}, 32'h0B);
    repeat (4) @(negedge PCLK);
    check("dw4_idle", {31'd0, BUSY4}, 32'd0);
    check("dw4_overrun", {31'd0, OVERRUN4}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
    $fatal(1);
  end

endmodule
